// File: rtl/mem_pkg.sv
// Shared definitions for the memory-stage alignment unit: access-type codes,
// FSM state encoding and size/legality decode helpers.
package mem_pkg;

  localparam logic [2:0] MT_B  = 3'b000;
  localparam logic [2:0] MT_H  = 3'b001;
  localparam logic [2:0] MT_W  = 3'b010;
  localparam logic [2:0] MT_BU = 3'b100;
  localparam logic [2:0] MT_HU = 3'b101;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SECOND = 1'b1
  } mem_state_e;

  // Byte count of an access; only mem_type[1:0] matters for legal codes.
  function automatic logic [2:0] size_decode(input logic [2:0] mem_type);
    case (mem_type[1:0])
      2'b00:   size_decode = 3'd1;
      2'b01:   size_decode = 3'd2;
      default: size_decode = 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] size_mask(input logic [2:0] mem_type);
    case (mem_type[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic type_legal(input logic [2:0] mem_type);
    case (mem_type)
      MT_B, MT_H, MT_W, MT_BU, MT_HU: type_legal = 1'b1;
      default:                        type_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_extract.sv
// Shifts the addressed bytes of a (possibly two-word) load down to lane 0 and
// applies sign or zero extension according to the access type.
module mem_lane_extract
  import mem_pkg::*;
(
  input  logic [63:0] data,
  input  logic [1:0]  off,
  input  logic [2:0]  mem_type,
  output logic [31:0] result
);

  logic [31:0] lane;

  assign lane = 32'(data >> {off, 3'b000});

  always_comb begin
    result = 32'h0;
    case (mem_type)
      MT_B:    result = {{24{lane[7]}}, lane[7:0]};
      MT_H:    result = {{16{lane[15]}}, lane[15:0]};
      MT_W:    result = lane;
      MT_BU:   result = {24'h0, lane[7:0]};
      MT_HU:   result = {16'h0, lane[15:0]};
      default: result = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_align_unit.sv
// Memory-stage alignment unit: byte enables, store lane steering, load
// extraction, and two-cycle splitting of accesses that cross a word boundary.
module mem_align_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        mem_type,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic [31:0]       dmem_rdata,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  output logic              dmem_re,
  output logic              dmem_we,
  output logic              stall,
  output logic              done,
  output logic [31:0]       load_data,
  output logic              access_err,
  output mem_state_e        fsm_state
);

  // Handshake: a request is presented with req_valid; it is accepted in the
  // cycle done=1. While stall=1 upstream holds all request inputs stable.

  mem_state_e        state_q, state_d;
  logic [1:0]        off_q;
  logic [2:0]        type_q;
  logic [ADDR_W-1:0] word_q;
  logic              rd_q, wr_q;
  logic [31:0]       wdata_hi_q;
  logic [3:0]        mask_hi_q;
  logic [31:0]       hold_q;

  logic [1:0]        off;
  logic [ADDR_W-1:0] word;
  logic [2:0]        size;
  logic              illegal;
  logic              crossing;
  logic              start_split;
  logic [7:0]        mask_wide;
  logic [63:0]       wdata_wide;

  logic [63:0]       ext_data;
  logic [1:0]        ext_off;
  logic [2:0]        ext_type;
  logic [31:0]       ext_result;
  logic              unused_addr;

  assign off         = addr[1:0];
  assign word        = addr[ADDR_W+1:2];
  assign size        = size_decode(mem_type);
  assign illegal     = !type_legal(mem_type) || (mem_read && mem_write);
  assign crossing    = ({2'b00, off} + {1'b0, size}) > 4'd4;
  assign mask_wide   = {4'b0000, size_mask(mem_type)} << off;
  assign wdata_wide  = {32'h0, wdata} << {off, 3'b000};
  assign start_split = (state_q == ST_IDLE) && req_valid && !illegal && crossing;
  assign unused_addr = ^addr[31:ADDR_W+2];
  assign fsm_state   = state_q;

  // The second half merges the held first word (low) with the new word (high).
  assign ext_data = (state_q == ST_SECOND) ? {dmem_rdata, hold_q} : {32'h0, dmem_rdata};
  assign ext_off  = (state_q == ST_SECOND) ? off_q  : off;
  assign ext_type = (state_q == ST_SECOND) ? type_q : mem_type;

  mem_lane_extract u_extract (
    .data     (ext_data),
    .off      (ext_off),
    .mem_type (ext_type),
    .result   (ext_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      off_q      <= 2'b00;
      type_q     <= 3'b000;
      word_q     <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      wdata_hi_q <= 32'h0;
      mask_hi_q  <= 4'b0000;
      hold_q     <= 32'h0;
    end else begin
      state_q <= state_d;
      if (start_split) begin
        off_q      <= off;
        type_q     <= mem_type;
        word_q     <= word;
        rd_q       <= mem_read;
        wr_q       <= mem_write;
        wdata_hi_q <= wdata_wide[63:32];
        mask_hi_q  <= mask_wide[7:4];
        hold_q     <= dmem_rdata;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    dmem_addr  = word;
    dmem_be    = 4'b0000;
    dmem_wdata = wdata_wide[31:0];
    dmem_re    = 1'b0;
    dmem_we    = 1'b0;
    stall      = 1'b0;
    done       = 1'b0;
    access_err = 1'b0;
    load_data  = 32'h0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (illegal) begin
            done       = 1'b1;
            access_err = 1'b1;
          end else begin
            dmem_be = mask_wide[3:0];
            dmem_re = mem_read;
            dmem_we = mem_write;
            if (crossing) begin
              stall   = 1'b1;
              state_d = ST_SECOND;
            end else begin
              done = 1'b1;
              if (mem_read) load_data = ext_result;
            end
          end
        end
      end
      ST_SECOND: begin
        state_d = ST_IDLE;
        // Reset in this cycle abandons the second half: nothing is written.
        if (!rst) begin
          dmem_addr  = word_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          dmem_be    = mask_hi_q;
          dmem_wdata = wdata_hi_q;
          dmem_re    = rd_q;
          dmem_we    = wr_q;
          done       = 1'b1;
          if (rd_q) load_data = ext_result;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: doc/mem_align_unit.md
MEM_ALIGN_UNIT -- requirements
Module: mem_align_unit

Interface
REQ-001 Parameter: ADDR_W, 16, word-index width of the data memory address.
REQ-002 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  memory-stage access request present this cycle.
REQ-005 mem_read  input  1  load request.
REQ-006 mem_write  input  1  store request.
REQ-007 mem_type  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU; other codes illegal.
REQ-008 addr  input  32  byte address from execute result.
REQ-009 wdata  input  32  store data (rs2 value).
REQ-010 dmem_rdata  input  32  data-memory word, combinational read of dmem_addr.
REQ-011 dmem_addr  output  ADDR_W  word index presented to data memory.
REQ-012 dmem_be  output  4  byte enables, bit i = byte lane i (little-endian).
REQ-013 dmem_wdata  output  32  lane-aligned store data.
REQ-014 dmem_re / dmem_we  output  1 each  read / write strobe.
REQ-015 stall  output  1  freeze upstream pipeline registers this cycle.
REQ-016 done  output  1  access completes this cycle.
REQ-017 load_data  output  32  extended load result, valid when done and mem_read.
REQ-018 access_err  output  1  illegal type or read+write both set; valid with done.

Function
REQ-019 size = 1/2/4 bytes from mem_type[1:0]; off = addr[1:0]; crossing = off+size > 4.
REQ-020 req_valid low: all strobes, be, done, stall, access_err SHALL be 0.
REQ-021 Illegal mem_type or mem_read&&mem_write: no strobes, done=1, access_err=1, stall=0, single cycle.
REQ-022 Non-crossing access: single cycle, stall=0, done=1; dmem_addr=addr[ADDR_W+1:2]; be=sizemask<<off.
REQ-023 Store lanes: dmem_wdata = wdata shifted left 8*off (lanes outside be don't-care).
REQ-024 Load extract: dmem_rdata shifted right 8*off, then sign-extend (B,H) or zero-extend (BU,HU); W unchanged.
REQ-025 FSM states IDLE, SECOND; crossing request in IDLE: access word A=addr[ADDR_W+1:2], be=(sizemask<<off)[3:0], stall=1, done=0, capture low-part bytes in hold register, go SECOND.
REQ-026 SECOND: access word A+1 (modulo 2^ADDR_W wrap), be=sizemask>>(4-off), stall=0, done=1, load_data = merge(hold, new bytes) then extend; return IDLE.
REQ-027 Store in split: first word gets wdata bytes low-to-high in lanes off..3, second word gets the remainder from lane 0.
REQ-028 Upstream holds req inputs stable while stall=1; unit uses registered off/type/size in SECOND regardless.
REQ-029 req_valid dropping in SECOND: second half SHALL still complete (committed access).
REQ-030 load_data SHALL be 0 whenever done=0 or mem_read=0.
REQ-031 Word accesses with off≠0 SHALL split; aligned W never stalls.

Reset
REQ-032 rst=1 at a rising edge: state IDLE, hold register 0; outputs combinationally follow REQ-020 for IDLE inputs.
REQ-033 rst during SECOND: second half SHALL be abandoned, no write issued next cycle, stall=0.

Structure
REQ-034 Shared package mem_pkg: mem_type encodings (MT_B, MT_H, MT_W, MT_BU, MT_HU), FSM state enum, size-decode function.
REQ-035 One sub-module natural: mem_lane_extract (shift + sign/zero extension), reused for aligned and merged paths.

Verification
REQ-036 Mem[0x10]=0x8899AABB; LB addr 0x41 -> 1 cycle, be=0010, load_data=0xFFFFFFAA, stall=0.
REQ-037 Same word, LHU addr 0x42 -> load_data=0x00008899, done=1, no stall.
REQ-038 Mem[0x10]=0x44332211, Mem[0x11]=0x88776655; LW addr 0x43 -> cycle1 stall=1 be=1000, cycle2 be=0111 done=1 load_data=0x77665544.
REQ-039 SW addr 0x46 wdata 0xDDCCBBAA -> cycle1 word 0x11 be=1100 lanes3:2=BBAA, cycle2 word 0x12 be=0011 lanes1:0=DDCC.
REQ-040 Split LH at word index 0xFFFF, off 3 -> second access dmem_addr=0x0000; rst asserted in SECOND -> no strobe next cycle, stall=0.
REQ-041 mem_type=011 with req_valid -> access_err=1, done=1, dmem_re=dmem_we=0.
